// File: rtl/tri_hit_pkg.sv
// Shared types and fixed-point helpers for the tri_hit point-in-triangle pipeline.
// Q_BITS fractional bits; vectors pack as {z,y,x} with x in the low word.
package tri_hit_pkg;

  localparam int TH_W      = 32;
  localparam int TH_Q_BITS = 10;
  localparam int TH_TAG_W  = 8;
  localparam int PIPE_LAT  = 4;

  typedef logic signed [TH_W-1:0]     fx_t;
  typedef logic signed [2*TH_W-1:0]   prod_t;
  typedef logic signed [2*TH_W+1:0]   dot_t;

  typedef struct packed {
    fx_t z;
    fx_t y;
    fx_t x;
  } vec3_t;

  typedef struct packed {
    logic                hit;
    logic [TH_TAG_W-1:0] tag;
  } res_t;

  function automatic prod_t fx_prod(input fx_t a, input fx_t b);
    return prod_t'(a) * prod_t'(b);
  endfunction

  // Single fixed-point product: full 2W result, arithmetic shift, truncate to W.
  function automatic fx_t fx_mul(input fx_t a, input fx_t b);
    prod_t w_p;
    w_p = fx_prod(a, b);
    return fx_t'(w_p >>> TH_Q_BITS);
  endfunction

  // Cross product component: difference taken on the full products before shifting.
  function automatic fx_t fx_cross_term(input fx_t a, input fx_t b, input fx_t c, input fx_t d);
    prod_t w_diff;
    w_diff = fx_prod(a, b) - fx_prod(c, d);
    return fx_t'(w_diff >>> TH_Q_BITS);
  endfunction

  function automatic vec3_t fx_cross(input vec3_t a, input vec3_t b);
    vec3_t w_c;
    w_c.x = fx_cross_term(a.y, b.z, a.z, b.y);
    w_c.y = fx_cross_term(a.z, b.x, a.x, b.z);
    w_c.z = fx_cross_term(a.x, b.y, a.y, b.x);
    return w_c;
  endfunction

  function automatic vec3_t vsub(input vec3_t a, input vec3_t b);
    vec3_t w_d;
    w_d.x = a.x - b.x;
    w_d.y = a.y - b.y;
    w_d.z = a.z - b.z;
    return w_d;
  endfunction

  function automatic dot_t fx_dot(input vec3_t a, input vec3_t b);
    return dot_t'(fx_prod(a.x, b.x)) + dot_t'(fx_prod(a.y, b.y)) + dot_t'(fx_prod(a.z, b.z));
  endfunction

endpackage

// File: rtl/tri_hit_buf.sv
// Show-ahead circular result FIFO; the extra pointer bit tells full from empty.
// A write lands in memory at the clock edge, so an empty FIFO shows it one cycle later.
module tri_hit_buf
  import tri_hit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_push,
  input  res_t i_data,
  input  logic i_pop,
  output logic o_valid,
  output res_t o_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  res_t         r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_empty;
  logic         w_full;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  a_no_overflow:  assert property (@(posedge clock) disable iff (reset) !(i_push && w_full));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset) !(i_pop && w_empty));

endmodule

// File: rtl/tri_hit_pipe.sv
// Pipelined point-in-triangle test with credit-based output flow control.
// Define TRI_HIT_TWO_SIDED_EN to also accept back-facing (all-negative) windings.
module tri_hit_pipe
  import tri_hit_pkg::*;
#(
  parameter int W         = TH_W,
  parameter int Q_BITS    = TH_Q_BITS,
  parameter int TAG_W     = TH_TAG_W,
  parameter int OUT_DEPTH = 8,
  parameter int EDGE_INCL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3*W-1:0]   p_hit,
  input  logic [3*W-1:0]   normal,
  input  logic [3*W-1:0]   v0,
  input  logic [3*W-1:0]   v1,
  input  logic [3*W-1:0]   v2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [TAG_W-1:0] out_tag
);

  if (W != TH_W || Q_BITS != TH_Q_BITS || TAG_W != TH_TAG_W) begin : g_bad_width
    $error("tri_hit_pipe: W/Q_BITS/TAG_W must match tri_hit_pkg");
  end
  if (OUT_DEPTH < PIPE_LAT || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tri_hit_pipe: OUT_DEPTH must be a power of 2 and >= PIPE_LAT");
  end

  localparam int   CW     = $clog2(OUT_DEPTH) + 1;
  localparam dot_t D_ZERO = '0;

  vec3_t w_p, w_n, w_v0, w_v1, w_v2;
  assign w_p  = p_hit;
  assign w_n  = normal;
  assign w_v0 = v0;
  assign w_v1 = v1;
  assign w_v2 = v2;

  logic          r_run;
  logic [CW-1:0] r_credits;
  logic          w_accept;
  logic          w_pop;

  assign in_ready = r_run && (r_credits != '0);
  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  // Credits cover every result in flight or buffered, so the pipeline never stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_credits <= CW'(OUT_DEPTH);
    end else begin
      r_run <= 1'b1;
      if (w_accept && !w_pop)      r_credits <= r_credits - CW'(1);
      else if (w_pop && !w_accept) r_credits <= r_credits + CW'(1);
    end
  end

  logic r_s1_valid, r_s2_valid, r_s3_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  vec3_t            r_s1_e [3];
  vec3_t            r_s1_p [3];
  vec3_t            r_s1_n, r_s2_n;
  vec3_t            r_s2_c [3];
  dot_t             r_s3_d [3];
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag;

  always_ff @(posedge clock) begin
    r_s1_e[0] <= vsub(w_v1, w_v0);
    r_s1_e[1] <= vsub(w_v2, w_v1);
    r_s1_e[2] <= vsub(w_v0, w_v2);
    r_s1_p[0] <= vsub(w_p, w_v0);
    r_s1_p[1] <= vsub(w_p, w_v1);
    r_s1_p[2] <= vsub(w_p, w_v2);
    r_s1_n    <= w_n;
    r_s1_tag  <= in_tag;

    for (int i = 0; i < 3; i++) r_s2_c[i] <= fx_cross(r_s1_e[i], r_s1_p[i]);
    r_s2_n   <= r_s1_n;
    r_s2_tag <= r_s1_tag;

    for (int i = 0; i < 3; i++) r_s3_d[i] <= fx_dot(r_s2_n, r_s2_c[i]);
    r_s3_tag <= r_s2_tag;
  end

  logic [2:0] w_pos;
  logic       w_hit;

`ifdef TRI_HIT_TWO_SIDED_EN
  logic [2:0] w_neg;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_pos[i] = (EDGE_INCL != 0) ? (r_s3_d[i] >= D_ZERO) : (r_s3_d[i] > D_ZERO);
      w_neg[i] = (EDGE_INCL != 0) ? (r_s3_d[i] <= D_ZERO) : (r_s3_d[i] < D_ZERO);
    end
  end
  assign w_hit = (&w_pos) || (&w_neg);
`else
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_pos[i] = (EDGE_INCL != 0) ? (r_s3_d[i] >= D_ZERO) : (r_s3_d[i] > D_ZERO);
    end
  end
  assign w_hit = &w_pos;
`endif

  res_t w_wr_data;
  res_t w_rd_data;
  assign w_wr_data = '{hit: w_hit, tag: r_s3_tag};

  tri_hit_buf #(
    .DEPTH (OUT_DEPTH)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_s3_valid),
    .i_data  (w_wr_data),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (w_rd_data)
  );

  assign out_hit = w_rd_data.hit;
  assign out_tag = w_rd_data.tag;

endmodule
